dmem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory port: accepts one load/store request at a time on a valid/ready channel, performs the word access with byte strobes, and returns a response after a fixed latency.
- Clocked by the memory clock domain and sits between the processor's dmem initiator and the word array.
- Replaces the zero-latency combinational dmem so the processor and bench can exercise stalls and error returns.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 94 +++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage with one byte-enabled write port and one enabled, registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                  clock_mem,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] wstrb,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // rdata only moves on a read, so it stays valid for the whole response phase
    always_ff @(posedge clock_mem) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency responder for the dmem port: one outstanding request, access
// executed at the accept edge, response held until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2     // 1..15
) (
    input  logic                  clock_mem,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [WORD_BYTES-1:0] req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             err_q, load_q;
    logic             accept, addr_err;
    logic [AW-1:0]    widx;
    logic [31:0]      arr_rdata;

    // full word index is compared so huge addresses cannot alias into range
    assign addr_err = (req_addr[ADDR_LSB-1:0] != '0) ||
                      (32'(req_addr[31:ADDR_LSB]) >= 32'(DEPTH_WORDS));
    assign accept   = (state == IDLE) && req_valid && !rst;
    assign widx     = req_addr[ADDR_LSB +: AW];

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clock_mem (clock_mem),
        .we        (accept && req_we && !addr_err),
        .waddr     (widx),
        .wdata     (req_wdata),
        .wstrb     (req_wstrb),
        .re        (accept && !req_we && !addr_err),
        .raddr     (widx),
        .rdata     (arr_rdata)
    );

    always_ff @(posedge clock_mem) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= CNT_INIT;
                err_q  <= addr_err;
                load_q <= !req_we;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = (LATENCY > 1) ? WAIT : RESP;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (load_q && !err_q) ? arr_rdata : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (LATENCY 2 and 1) checked
// every cycle against a timestamp-based transaction model.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic [31:0] resp_rdata[2];
    logic        resp_err  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (
        .clock_mem(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clock_mem(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: a transaction is a timestamp. Response is due LAT edges after accept
    // and is retired by the first edge at or after that with resp_ready high.
    int              edge_n = 0;
    bit              busy     [2];
    int              acc      [2];
    logic [31:0]     exp_data [2];
    bit              exp_err  [2];
    bit              exp_known[2];
    logic [31:0]     mm       [2][DEPTH];
    bit              wr       [2][DEPTH];
    longint unsigned m_a;
    bit              m_err;
    int              m_idx;
    bit              chk_on = 0;
    bit              b2b_on = 0;
    logic [31:0]     q_data[$];
    int              q_edge[$];

    initial begin
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0;
            for (int i = 0; i < DEPTH; i++) wr[d][i] = 0;
        end
    end

    always @(posedge clk) begin
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                busy[d] = 0;
            end else if (busy[d]) begin
                if (edge_n >= acc[d] + lat(d) && resp_ready[d]) busy[d] = 0;
            end else if (req_valid[d]) begin
                m_a   = 64'(req_addr[d]);
                m_err = (m_a % 4 != 0) || (m_a / 4 >= DEPTH);
                busy[d] = 1; acc[d] = edge_n;
                exp_err[d] = m_err; exp_data[d] = 0; exp_known[d] = 1;
                if (!m_err) begin
                    m_idx = int'(m_a / 4);
                    if (req_we[d]) begin
                        for (int i = 0; i < 4; i++)
                            if (req_wstrb[d][i]) mm[d][m_idx][8*i +: 8] = req_wdata[d][8*i +: 8];
                        if (req_wstrb[d] == 4'hF) wr[d][m_idx] = 1;
                    end else begin
                        exp_data[d]  = mm[d][m_idx];
                        exp_known[d] = wr[d][m_idx];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                automatic bit ev = busy[d] && (edge_n >= acc[d] + lat(d) - 1);
                chk($sformatf("req_ready[%0d]", d), 32'(req_ready[d]), 32'(!busy[d]));
                chk($sformatf("resp_valid[%0d]", d), 32'(resp_valid[d]), 32'(ev));
                if (ev && exp_known[d]) begin
                    chk($sformatf("resp_rdata[%0d]", d), resp_rdata[d], exp_data[d]);
                    chk($sformatf("resp_err[%0d]", d), 32'(resp_err[d]), 32'(exp_err[d]));
                end
            end
            if (b2b_on && resp_valid[1] && resp_ready[1]) begin
                q_data.push_back(resp_rdata[1]);
                q_edge.push_back(edge_n);
            end
        end
    end

    task automatic txn(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat_seen);
        int n, acc_e;
        @(negedge clk);
        req_valid[d] = 1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_wstrb[d] = strb; resp_ready[d] = (hold == 0);
        n = 0;
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        acc_e = edge_n;
        // scramble request fields: they must be ignored after acceptance
        req_valid[d] = 0; req_addr[d] = $urandom; req_wdata[d] = $urandom;
        req_we[d] = 1'($urandom_range(0, 1)); req_wstrb[d] = 4'($urandom_range(0, 15));
        n = 0;
        while (!resp_valid[d] && n < 50) begin @(negedge clk); n++; end
        chk("resp_timeout", 32'(n < 50), 32'd1);
        lat_seen = edge_n + 1 - acc_e;
        rdata = resp_rdata[d];
        err   = resp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid[d]), 32'd1);
            chk("hold_rdata", resp_rdata[d], rdata);
            chk("hold_err", 32'(resp_err[d]), 32'(err));
            chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        resp_ready[d] = 1;
        @(negedge clk);
        if (hold > 0) chk("release_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ls, n;
        int          acc_e[4];

        rst = 1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 0; req_we[d] = 0; req_addr[d] = 0;
            req_wdata[d] = 0; req_wstrb[d] = 0; resp_ready[d] = 1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
        end
        rst = 0;
        chk_on = 1;

        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, ls);
        chk("store_latency", 32'(ls), 32'd2);
        chk("store_rdata", rd, 32'd0);
        chk("store_err", 32'(er), 32'd0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, ls);
        chk("load_0x10", rd, 32'hDEADBEEF);
        chk("load_latency", 32'(ls), 32'd2);

        txn(0, 1, 32'h10, 32'h01020304, 4'h0, 0, rd, er, ls);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, ls);
        chk("nop_store_0x10", rd, 32'hDEADBEEF);

        txn(0, 1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, ls);
        txn(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, er, ls);
        txn(0, 0, 32'h20, 32'h0, 4'hF, 0, rd, er, ls);
        chk("strobe_0x20", rd, 32'h11BB33DD);

        txn(0, 0, 32'h22, 32'h0, 4'h0, 0, rd, er, ls);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        txn(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, rd, er, ls);
        txn(0, 1, 32'h400, 32'h12345678, 4'hF, 0, rd, er, ls);
        chk("oob_store_err", 32'(er), 32'd1);
        txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, ls);
        chk("high_addr_err", 32'(er), 32'd1);
        txn(0, 0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, ls);
        chk("last_word_kept", rd, 32'hCAFEF00D);
        chk("last_word_err", 32'(er), 32'd0);

        txn(0, 0, 32'h20, 32'h0, 4'h0, 5, rd, er, ls);
        chk("bp_rdata", rd, 32'h11BB33DD);

        // reset while a store sits in WAIT
        @(negedge clk);
        req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'd7; req_wstrb[0] = 4'hF;
        n = 0;
        while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[0] = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_resp", 32'(resp_valid[0]), 32'd0);
            @(negedge clk);
        end
        chk("rst_mid_req_ready", 32'(req_ready[0]), 32'd1);
        txn(0, 0, 32'h30, 32'h0, 4'h0, 0, rd, er, ls);
        chk("rst_mid_store_kept", rd, 32'd7);

        // reset and a request in the same cycle: reset wins
        txn(0, 1, 32'h40, 32'h55, 4'hF, 0, rd, er, ls);
        @(negedge clk);
        rst = 1; req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h40;
        req_wdata[0] = 32'h99; req_wstrb[0] = 4'hF;
        @(negedge clk);
        rst = 0; req_valid[0] = 0;
        txn(0, 0, 32'h40, 32'h0, 4'h0, 0, rd, er, ls);
        chk("rst_vs_req", rd, 32'h55);

        // LATENCY=1 back-to-back loads
        for (int k = 0; k < 4; k++)
            txn(1, 1, 32'(4*k), 32'h1111_0000 + 32'(k), 4'hF, 0, rd, er, ls);
        b2b_on = 1;
        @(negedge clk);
        req_valid[1] = 1; req_we[1] = 0; resp_ready[1] = 1;
        for (int k = 0; k < 4; k++) begin
            req_addr[1] = 32'(4*k);
            n = 0;
            while (!req_ready[1] && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
            acc_e[k] = edge_n;
        end
        req_valid[1] = 0;
        repeat (3) @(negedge clk);
        b2b_on = 0;
        for (int k = 1; k < 4; k++) chk("b2b_accept_gap", 32'(acc_e[k] - acc_e[k-1]), 32'd2);
        chk("b2b_count", 32'(q_data.size()), 32'd4);
        if (q_data.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("b2b_data", q_data[k], 32'h1111_0000 + 32'(k));
            for (int k = 1; k < 4; k++) chk("b2b_resp_gap", 32'(q_edge[k] - q_edge[k-1]), 32'd2);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
